// File: rtl/mmr_tmr_pkg.sv
// Shared types and the bitwise majority helper for the
// K-modular redundant MMR register slots.
package mmr_tmr_pkg;

   localparam int TMR_MIN_K = 3;
   localparam int TMR_MAX_K = 31;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CHECK,
      FIX
   } scrub_state_t;

   // Majority of the low k bits of word (one bit position across replicas).
   function automatic logic maj_vote(input int k,
                                     input logic [TMR_MAX_K-1:0] word);
      int ones;
      ones = 0;
      for (int i = 0; i < TMR_MAX_K; i++) begin
         if (i < k) ones += int'(word[i]);
      end
      return (ones > k / 2);
   endfunction

endpackage

// File: rtl/mmr_scrub_timer.sv
// Scrub period counter: counts while enabled, terminal-count
// pulse at PERIOD-1, then wraps to zero.
module mmr_scrub_timer #(
   parameter int PERIOD = 1024
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int CW = $clog2(PERIOD);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = en_i && (cnt_q == CW'(PERIOD - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) cnt_d = '0;
      else if (en_i) cnt_d = tc_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mmr_scrub_register.sv
// K-modular redundant register with periodic vote-and-rewrite scrubbing.
// Optional fault-injection ports under MMR_SCRUB_ERR_INJECT_EN.
module mmr_scrub_register
   import mmr_tmr_pkg::*;
#(
   parameter int               K_MMR        = 3,
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int               SCRUB_PERIOD = 1024,
   parameter int               ERR_CNT_W    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   wr_valid_i,
   output logic                   wr_ready_o,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic                   scrub_en_i,
   output logic [K_MMR*WIDTH-1:0] replicas_o,
   output logic [WIDTH-1:0]       voted_o,
   output logic                   mismatch_o,
   output logic                   scrub_fix_o,
   output logic [ERR_CNT_W-1:0]   err_cnt_o,
`ifdef MMR_SCRUB_ERR_INJECT_EN
   input  logic                   inj_valid_i,
   input  logic [K_MMR*WIDTH-1:0] inj_mask_i,
`endif
   input  logic                   err_clr_i
);

   localparam int NW = K_MMR * WIDTH;

   if (K_MMR < TMR_MIN_K || K_MMR > TMR_MAX_K || (K_MMR % 2) == 0) begin : g_bad_k
      $error("mmr_scrub_register: K_MMR must be odd and >= 3");
   end
   if (SCRUB_PERIOD < 2) begin : g_bad_p
      $error("mmr_scrub_register: SCRUB_PERIOD must be >= 2");
   end

   // Replicas must survive synthesis as distinct flops.
   (* keep = "true", dont_touch = "true" *)
   logic [NW-1:0]        rep_q;
   logic [NW-1:0]        rep_d;
   scrub_state_t         state_q;
   logic [WIDTH-1:0]     cap_q;
   logic [ERR_CNT_W-1:0] err_q;
   logic [WIDTH-1:0]     voted;
   logic                 mism;
   logic                 wr_hs;
   logic                 tc;

   for (genvar b = 0; b < WIDTH; b++) begin : g_vote
      logic [TMR_MAX_K-1:0] col;
      always_comb begin
         col = '0;
         for (int k = 0; k < K_MMR; k++) col[k] = rep_q[k*WIDTH + b];
      end
      assign voted[b] = maj_vote(K_MMR, col);
   end

   always_comb begin
      mism = 1'b0;
      for (int k = 0; k < K_MMR; k++) begin
         if (rep_q[k*WIDTH +: WIDTH] != voted) mism = 1'b1;
      end
   end

   assign wr_ready_o = (state_q != FIX);
   assign wr_hs      = wr_valid_i && wr_ready_o;

   mmr_scrub_timer #(
      .PERIOD (SCRUB_PERIOD)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (state_q == WAIT),
      .clr_i   ((state_q != WAIT) || !scrub_en_i),
      .tc_o    (tc)
   );

   always_comb begin
      rep_d = rep_q;
      if (state_q == FIX)  rep_d = {K_MMR{cap_q}};
      else if (wr_hs)      rep_d = {K_MMR{wr_data_i}};
`ifdef MMR_SCRUB_ERR_INJECT_EN
      else if (inj_valid_i) rep_d = rep_q ^ inj_mask_i;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rep_q <= {K_MMR{RESET_VALUE}};
      else          rep_q <= rep_d;
   end

   // A write landing in CHECK wins over the stale vote for the FIX rewrite.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cap_q   <= RESET_VALUE;
      end else begin
         unique case (state_q)
            IDLE: if (scrub_en_i) state_q <= WAIT;
            WAIT: begin
               if (!scrub_en_i) state_q <= IDLE;
               else if (tc)     state_q <= CHECK;
            end
            CHECK: begin
               cap_q <= wr_hs ? wr_data_i : voted;
               if (mism)            state_q <= FIX;
               else if (scrub_en_i) state_q <= WAIT;
               else                 state_q <= IDLE;
            end
            FIX:     state_q <= scrub_en_i ? WAIT : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         err_q <= '0;
      else if (err_clr_i)
         err_q <= '0;
      else if (state_q == FIX && err_q != '1)
         err_q <= err_q + ERR_CNT_W'(1);
   end

   assign replicas_o  = rep_q;
   assign voted_o     = voted;
   assign mismatch_o  = mism;
   assign scrub_fix_o = (state_q == FIX);
   assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_mmr_scrub_register.sv
// Self-checking bench for mmr_scrub_register: directed table,
// scrub corner sequences and a randomized run against a model.
module tb_mmr_scrub_register;

   localparam int K  = 3;
   localparam int W  = 8;
   localparam int P  = 16;
   localparam int EW = 8;
   localparam int NW = K * W;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [W-1:0]  wr_data  = '0;
   logic          scrub_en = 1'b0;
   logic [NW-1:0] reps;
   logic [W-1:0]  voted;
   logic          mism;
   logic          fix;
   logic [EW-1:0] errc;
   logic          err_clr  = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mmr_scrub_register #(
      .K_MMR        (K),
      .WIDTH        (W),
      .RESET_VALUE  (8'h00),
      .SCRUB_PERIOD (P),
      .ERR_CNT_W    (EW)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .wr_valid_i  (wr_valid),
      .wr_ready_o  (wr_ready),
      .wr_data_i   (wr_data),
      .scrub_en_i  (scrub_en),
      .replicas_o  (reps),
      .voted_o     (voted),
      .mismatch_o  (mism),
      .scrub_fix_o (fix),
      .err_cnt_o   (errc),
`ifdef MMR_SCRUB_ERR_INJECT_EN
      .inj_valid_i (1'b0),
      .inj_mask_i  ({NW{1'b0}}),
`endif
      .err_clr_i   (err_clr)
   );

   // Reference model: replica words, a scrub phase counter
   // (-1 idle, 0..P-1 waiting, P checking, P+1 fixing).
   logic [W-1:0] m_rep [K];
   int           m_ph;
   logic [W-1:0] m_cap;
   int           m_err;

   function automatic logic [W-1:0] m_vote();
      logic [W-1:0] v;
      int n;
      for (int b = 0; b < W; b++) begin
         n = 0;
         for (int k = 0; k < K; k++) n += int'(m_rep[k][b]);
         v[b] = (2 * n > K);
      end
      return v;
   endfunction

   function automatic logic m_mism();
      logic [W-1:0] v;
      v = m_vote();
      for (int k = 0; k < K; k++) if (m_rep[k] != v) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [NW-1:0] m_pack();
      logic [NW-1:0] p;
      for (int k = 0; k < K; k++) p[k*W +: W] = m_rep[k];
      return p;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < K; k++) m_rep[k] = '0;
      m_ph  = -1;
      m_cap = '0;
      m_err = 0;
   endtask

   task automatic m_step();
      logic [W-1:0] v;
      logic mm, in_fix, acc;
      int nph;
      v      = m_vote();
      mm     = m_mism();
      in_fix = (m_ph == P + 1);
      acc    = wr_valid && !in_fix;
      if (err_clr) m_err = 0;
      else if (in_fix && m_err < (1 << EW) - 1) m_err++;
      if (in_fix) begin
         for (int k = 0; k < K; k++) m_rep[k] = m_cap;
      end else if (acc) begin
         for (int k = 0; k < K; k++) m_rep[k] = wr_data;
      end
      if (m_ph == P) m_cap = acc ? wr_data : v;
      if (m_ph < 0)       nph = scrub_en ? 0 : -1;
      else if (m_ph < P)  nph = scrub_en ? m_ph + 1 : -1;
      else if (m_ph == P) nph = mm ? P + 1 : (scrub_en ? 0 : -1);
      else                nph = scrub_en ? 0 : -1;
      m_ph = nph;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      chk("replicas", 64'(reps), 64'(m_pack()));
      chk("voted", 64'(voted), 64'(m_vote()));
      chk("mismatch", 64'(mism), 64'(m_mism()));
      chk("scrub_fix", 64'(fix), 64'(m_ph == P + 1));
      chk("wr_ready", 64'(wr_ready), 64'(m_ph != P + 1));
      chk("err_cnt", 64'(errc), 64'(m_err));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) m_step();
      else       m_reset();
      @(negedge clk);
      cmp_all();
   endtask

   // Upset replica bits directly in the flops, then let them hold.
   task automatic corrupt(input logic [NW-1:0] mask);
      logic [NW-1:0] v;
      for (int k = 0; k < K; k++) m_rep[k] = m_rep[k] ^ mask[k*W +: W];
      v = m_pack();
      force dut.rep_q = v;
      #1;
      release dut.rep_q;
      cmp_all();
   endtask

   task automatic wait_fix(output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (fix) begin
            got = 1'b1;
            break;
         end
      end
      chk("fix_timeout", 64'(got), 64'(1));
   endtask

   typedef struct {
      logic         wv;
      logic [W-1:0] wd;
      logic [W-1:0] exp_v;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int first;
      bit ok;

      tbl[0] = '{1'b1, 8'hA5, 8'hA5};
      tbl[1] = '{1'b0, 8'h00, 8'hA5};
      tbl[2] = '{1'b1, 8'h3C, 8'h3C};
      tbl[3] = '{1'b1, 8'hFF, 8'hFF};
      tbl[4] = '{1'b0, 8'h12, 8'hFF};
      tbl[5] = '{1'b1, 8'h00, 8'h00};
      tbl[6] = '{1'b1, 8'hA5, 8'hA5};

      m_reset();
      rst_n = 1'b0;
      cyc();
      chk("rst_replicas", 64'(reps), 64'(0));
      chk("rst_voted", 64'(voted), 64'(0));
      chk("rst_mismatch", 64'(mism), 64'(0));
      chk("rst_fix", 64'(fix), 64'(0));
      chk("rst_err", 64'(errc), 64'(0));
      chk("rst_ready", 64'(wr_ready), 64'(1));
      cyc();
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         wr_valid = tbl[i].wv;
         wr_data  = tbl[i].wd;
         cyc();
         chk("tbl_voted", 64'(voted), 64'(tbl[i].exp_v));
         chk("tbl_reps", 64'(reps), 64'({K{tbl[i].exp_v}}));
         chk("tbl_mism", 64'(mism), 64'(0));
      end
      wr_valid = 1'b0;

      corrupt(24'h000100);
      chk("inj_mismatch", 64'(mism), 64'(1));
      chk("inj_voted", 64'(voted), 64'(8'hA5));
      scrub_en = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (fix) pulses++;
      end
      chk("fix_pulses", 64'(pulses), 64'(1));
      chk("fix_reps", 64'(reps), 64'(24'hA5A5A5));
      chk("fix_err", 64'(errc), 64'(1));

      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      pulses = 0;
      for (int i = 0; i < 160; i++) begin
         cyc();
         if (fix) pulses++;
      end
      chk("clean_pulses", 64'(pulses), 64'(0));
      chk("clean_err", 64'(errc), 64'(0));

      scrub_en = 1'b0;
      cyc();
      cyc();
      corrupt(24'h010000);
      scrub_en = 1'b1;
      for (int i = 0; i < 17; i++) cyc();
      chk("check_ready", 64'(wr_ready), 64'(1));
      chk("check_nofix", 64'(fix), 64'(0));
      wr_valid = 1'b1;
      wr_data  = 8'h3C;
      cyc();
      wr_valid = 1'b0;
      chk("fixcyc_ready", 64'(wr_ready), 64'(0));
      chk("fixcyc_fix", 64'(fix), 64'(1));
      chk("fixcyc_reps", 64'(reps), 64'(24'h3C3C3C));
      cyc();
      chk("afterfix_ready", 64'(wr_ready), 64'(1));
      chk("afterfix_reps", 64'(reps), 64'(24'h3C3C3C));
      chk("afterfix_err", 64'(errc), 64'(1));

      ok = 1'b1;
      for (int n = 0; n < 260 && ok; n++) begin
         corrupt(NW'(1) << $urandom_range(0, NW - 1));
         wait_fix(ok);
         cyc();
      end
      chk("sat_err", 64'(errc), 64'(8'hFF));

      corrupt(24'h000004);
      wait_fix(ok);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("clr_over_fix", 64'(errc), 64'(0));

      cyc();
      corrupt(24'h000080);
      wait_fix(ok);
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("arst_replicas", 64'(reps), 64'(0));
      chk("arst_voted", 64'(voted), 64'(0));
      chk("arst_err", 64'(errc), 64'(0));
      chk("arst_fix", 64'(fix), 64'(0));
      chk("arst_ready", 64'(wr_ready), 64'(1));
      cyc();
      cyc();
      rst_n = 1'b1;
      corrupt(24'h000001);
      first = -1;
      for (int i = 1; i <= 25; i++) begin
         cyc();
         if (fix && first < 0) first = i;
      end
      chk("restart_fix_cycle", 64'(first), 64'(18));

      for (int i = 0; i < 3000; i++) begin
         wr_valid = ($urandom_range(0, 4) == 0);
         wr_data  = W'($urandom);
         if ($urandom_range(0, 63) == 0) scrub_en = !scrub_en;
         err_clr = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 11) == 0)
            corrupt(NW'(1) << $urandom_range(0, NW - 1));
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmr_scrub_register.md
Name: mmr_scrub_register

Overview:
- K-modular redundant storage register: the write-side counterpart of the majority voters used in the MMR register bank.
- Fans one written word out into K_MMR identical replicas and exposes the voted value.
- A periodic scrub FSM re-votes the replicas and rewrites all of them, so single-replica upsets do not accumulate.
- Sits behind each MMR control-register slot; the replicas are exported packed for VHDL compatibility.

Parameters:
- K_MMR, 3, number of replicas; must be odd and >= 3 (elaboration $error otherwise).
- WIDTH, 16, bits per replica.
- RESET_VALUE, 0, value loaded into every replica on reset (WIDTH bits).
- SCRUB_PERIOD, 1024, cycles between scrub checks; >= 2.
- ERR_CNT_W, 8, width of the saturating scrub-error counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accepted when high with wr_valid_i.
- wr_data_i  in  WIDTH  write data.
- scrub_en_i  in  1  enables periodic scrubbing.
- replicas_o  out  K_MMR*WIDTH  packed replicas; replica k is at [k*WIDTH +: WIDTH].
- voted_o  out  WIDTH  bitwise majority of the replicas.
- mismatch_o  out  1  any replica differs from voted_o.
- scrub_fix_o  out  1  one-cycle pulse when a scrub rewrote the replicas.
- err_cnt_o  out  ERR_CNT_W  count of scrubs that found a mismatch.
- err_clr_i  in  1  synchronous clear of err_cnt_o.

Behaviour:
- Reset values:
  - all replicas = RESET_VALUE; voted_o = RESET_VALUE.
  - mismatch_o = 0, scrub_fix_o = 0, err_cnt_o = 0, wr_ready_o = 1.
  - FSM in IDLE, period timer = 0.
- voted_o and mismatch_o are combinational from the replica flops: zero latency.
- Write: a handshake in cycle n sets every replica to wr_data_i at edge n+1, so voted_o shows the new value in cycle n+1.
- wr_ready_o = 0 only while the FSM is in FIX.
- FSM states:
  - IDLE: timer held at 0. Go to WAIT when scrub_en_i = 1.
  - WAIT: timer increments each cycle. At SCRUB_PERIOD-1, go to CHECK and clear the timer. If scrub_en_i drops, return to IDLE and clear the timer.
  - CHECK (1 cycle): capture voted_o and mismatch_o. If mismatch, go to FIX. Otherwise go to WAIT, or to IDLE if scrub_en_i = 0.
  - FIX (1 cycle): write the captured voted value into all replicas, pulse scrub_fix_o, increment err_cnt_o. Then go to WAIT, or to IDLE if scrub_en_i = 0.
- Write during CHECK: the write is accepted and wins. The mismatch captured in CHECK still goes to FIX, which rewrites the replicas with the new write data instead of the stale vote, and still increments err_cnt_o.
- err_cnt_o saturates at all-ones.
- err_clr_i has priority over an increment in the same cycle; the result is 0.
- Reset asserted mid-FIX: all state returns to reset values immediately (async). No partial write persists.
- The replica flops carry DONT_TOUCH / keep so synthesis does not merge them.

Optional Feature:
- Macro: MMR_SCRUB_ERR_INJECT_EN.
- When defined, two ports are added:
  - inj_valid_i (1 bit).
  - inj_mask_i (K_MMR*WIDTH bits).
- A cycle with inj_valid_i = 1 XORs inj_mask_i into the packed replicas at the next edge. This has lower priority than a write or FIX in the same cycle; injection is dropped in that case.
- When undefined, these ports do not exist and the replicas change only by reset, write or FIX.

Decomposition:
- Package mmr_tmr_pkg holds:
  - typedef scrub_state_t (IDLE, WAIT, CHECK, FIX).
  - function maj_vote(K, word) returning the bitwise majority.
  - constant TMR_MIN_K = 3.
- One natural sub-module: mmr_scrub_timer, the period counter with enable, clear and a terminal-count pulse.
- The voting logic reuses the existing packed majority voter per bit, or the package function.

Test Plan (K_MMR=3, WIDTH=8, SCRUB_PERIOD=16):
- Reset release, then write 0xA5: replicas_o = 0xA5A5A5 and voted_o = 0xA5 one cycle after the handshake; mismatch_o = 0.
- Inject mask 0x000100 (replica 1, bit 0), scrub_en_i = 1: mismatch_o = 1 and voted_o stays 0xA5. Within 16+2 cycles scrub_fix_o pulses once, replicas return to 0xA5A5A5 and err_cnt_o = 1.
- No corruption, scrub enabled for 160 cycles: no scrub_fix_o pulse, err_cnt_o = 0.
- Corrupt, then write 0x3C in the same cycle FSM is in CHECK: after FIX the replicas = 0x3C3C3C, err_cnt_o increments, and wr_ready_o = 0 only for the FIX cycle.
- Force 256 fix events: err_cnt_o saturates at 0xFF. Assert err_clr_i together with a FIX: err_cnt_o = 0.
- Deassert rst_n_i during FIX: outputs reset asynchronously (replicas 0x000000, err_cnt_o = 0); after release, FSM restarts from IDLE.
